// File: rtl/regarb_pkg.sv
// Shared types and default sizing for the register-file write arbiter and debug read port.
// Optional feature macro: REGARB_ZERO_PROTECT_EN (register 0 hard-wired to zero).
package regarb_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_STARVE_MAX = 4;
    localparam int STARVE_CNT_W   = 3;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_RESP  = 2'd2
    } rd_state_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [STARVE_CNT_W-1:0] sat_inc(
        input logic [STARVE_CNT_W-1:0] value,
        input logic [STARVE_CNT_W-1:0] limit
    );
        return (value >= limit) ? limit : value + 3'd1;
    endfunction

endpackage

// File: rtl/regarb_starve_ctr.sv
// Counts consecutive cycles a debug write waits behind the core and raises the
// forced-grant flag once the wait reaches STARVE_MAX.
module regarb_starve_ctr
    import regarb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    dbg_valid,
    input  logic                    dbg_accept,
    output logic [STARVE_CNT_W-1:0] count,
    output logic                    force_grant
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_MAX);

    // The count only survives while a debug write is continuously pending and refused.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!dbg_valid || dbg_accept) begin
            count <= '0;
        end else begin
            count <= sat_inc(count, LIMIT);
        end
    end

    assign force_grant = (count == LIMIT);

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates core and debug writes into a single register-file write port and
// serves debug reads with write bypass. Optional macro: REGARB_ZERO_PROTECT_EN.
module regfile_arbiter
    import regarb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    core_wr_valid,
    input  logic [ADDR_W-1:0]       core_wr_addr,
    input  logic [DATA_W-1:0]       core_wr_data,
    output logic                    core_wr_ready,

    input  logic                    dbg_wr_valid,
    input  logic [ADDR_W-1:0]       dbg_wr_addr,
    input  logic [DATA_W-1:0]       dbg_wr_data,
    output logic                    dbg_wr_ready,

    input  logic                    dbg_rd_valid,
    input  logic [ADDR_W-1:0]       dbg_rd_addr,
    output logic                    dbg_rd_ready,
    output logic                    dbg_rd_rvalid,
    output logic [DATA_W-1:0]       dbg_rd_rdata,
    input  logic                    dbg_rd_rack,

    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [ADDR_W-1:0]       rf_raddr,
    input  logic [DATA_W-1:0]       rf_rdata,

    output logic [STARVE_CNT_W-1:0] starve_cnt
);

    logic              force_grant;
    logic              core_acc;
    logic              dbg_acc;
    logic              wr_acc;
    logic              wr_commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_capture;
    rd_state_t         rd_state;

    regarb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .reset_n     (reset_n),
        .dbg_valid   (dbg_wr_valid),
        .dbg_accept  (dbg_acc),
        .count       (starve_cnt),
        .force_grant (force_grant)
    );

    // Readies are gated by reset_n so nothing is offered during reset, yet the
    // first edge after release can already complete a handshake.
    assign core_wr_ready = reset_n && !force_grant;
    assign dbg_wr_ready  = reset_n && (!core_wr_valid || force_grant);
    assign dbg_rd_ready  = reset_n && (rd_state == RD_IDLE);

    assign core_acc = core_wr_valid && core_wr_ready;
    assign dbg_acc  = dbg_wr_valid && dbg_wr_ready;
    assign wr_acc   = core_acc || dbg_acc;
    assign wr_addr  = core_acc ? core_wr_addr : dbg_wr_addr;
    assign wr_data  = core_acc ? core_wr_data : dbg_wr_data;

`ifdef REGARB_ZERO_PROTECT_EN
    assign wr_commit = wr_acc && (wr_addr != '0);
`else
    assign wr_commit = wr_acc;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wr_commit;
            if (wr_acc) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
        end
    end

    // A write retiring in the same cycle as the read lookup is newer than the array contents.
    always_comb begin
        rd_capture = rf_rdata;
        if (rf_we && (rf_waddr == rf_raddr)) begin
            rd_capture = rf_wdata;
        end
`ifdef REGARB_ZERO_PROTECT_EN
        if (rf_raddr == '0) begin
            rd_capture = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_state      <= RD_IDLE;
            rf_raddr      <= '0;
            dbg_rd_rdata  <= '0;
            dbg_rd_rvalid <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (dbg_rd_valid) begin
                        rf_raddr <= dbg_rd_addr;
                        rd_state <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    dbg_rd_rdata  <= rd_capture;
                    dbg_rd_rvalid <= 1'b1;
                    rd_state      <= RD_RESP;
                end
                RD_RESP: begin
                    if (dbg_rd_rack) begin
                        dbg_rd_rvalid <= 1'b0;
                        rd_state      <= RD_IDLE;
                    end
                end
                default: begin
                    dbg_rd_rvalid <= 1'b0;
                    rd_state      <= RD_IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(core_acc && dbg_acc));
    assert property (@(posedge clk) disable iff (!reset_n) dbg_rd_rvalid == (rd_state == RD_RESP));

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of arbitration, write latency and reads.
module tb_regfile_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 4;
`ifdef REGARB_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              core_wr_valid;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_wr_ready;
    logic              dbg_wr_valid;
    logic [ADDR_W-1:0] dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;
    logic              dbg_wr_ready;
    logic              dbg_rd_valid;
    logic [ADDR_W-1:0] dbg_rd_addr;
    logic              dbg_rd_ready;
    logic              dbg_rd_rvalid;
    logic [DATA_W-1:0] dbg_rd_rdata;
    logic              dbg_rd_rack;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [2:0]        starve_cnt;

    int checks = 0;
    int errors = 0;

    // Register array behind the arbiter, driven only by the DUT write port.
    logic [DATA_W-1:0] rf_mem [32] = '{default: '0};
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    always #5 clk = ~clk;

    regfile_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .core_wr_valid (core_wr_valid),
        .core_wr_addr  (core_wr_addr),
        .core_wr_data  (core_wr_data),
        .core_wr_ready (core_wr_ready),
        .dbg_wr_valid  (dbg_wr_valid),
        .dbg_wr_addr   (dbg_wr_addr),
        .dbg_wr_data   (dbg_wr_data),
        .dbg_wr_ready  (dbg_wr_ready),
        .dbg_rd_valid  (dbg_rd_valid),
        .dbg_rd_addr   (dbg_rd_addr),
        .dbg_rd_ready  (dbg_rd_ready),
        .dbg_rd_rvalid (dbg_rd_rvalid),
        .dbg_rd_rdata  (dbg_rd_rdata),
        .dbg_rd_rack   (dbg_rd_rack),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .starve_cnt    (starve_cnt)
    );

    // Reference model state: register contents, pending write, stall count, read progress.
    logic [DATA_W-1:0] exp_mem [32];
    int                cnt_m;
    bit                pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    int                rd_phase;
    logic [ADDR_W-1:0] rd_addr_m;
    logic [DATA_W-1:0] rd_data_m;
    bit                last_dacc;

    function automatic bit m_core_rdy();
        return reset_n && (cnt_m != STARVE_MAX);
    endfunction

    function automatic bit m_dbg_rdy();
        return reset_n && (!core_wr_valid || (cnt_m == STARVE_MAX));
    endfunction

    function automatic bit m_rd_rdy();
        return reset_n && (rd_phase == 0);
    endfunction

    task automatic idle_inputs();
        core_wr_valid = 1'b0; core_wr_addr = '0; core_wr_data = '0;
        dbg_wr_valid  = 1'b0; dbg_wr_addr  = '0; dbg_wr_data  = '0;
        dbg_rd_valid  = 1'b0; dbg_rd_addr  = '0; dbg_rd_rack  = 1'b0;
    endtask

    // Advance one clock and move the reference model by the rules of the arbiter.
    task automatic tick();
        bit rst, cv, dv, rv, rk, frc, cacc, dacc;
        logic [ADDR_W-1:0] ca, da, ra;
        logic [DATA_W-1:0] cd, dd;
        rst = !reset_n;
        cv = core_wr_valid; ca = core_wr_addr; cd = core_wr_data;
        dv = dbg_wr_valid;  da = dbg_wr_addr;  dd = dbg_wr_data;
        rv = dbg_rd_valid;  ra = dbg_rd_addr;  rk = dbg_rd_rack;
        frc  = (cnt_m == STARVE_MAX);
        cacc = cv && !frc;
        dacc = dv && (!cv || frc);
        @(posedge clk);
        #1;
        if (pend_we) exp_mem[pend_addr] = pend_data;
        if (rst) begin
            pend_we = 1'b0; cnt_m = 0; rd_phase = 0; rd_data_m = '0; last_dacc = 1'b0;
        end else begin
            last_dacc = dacc;
            case (rd_phase)
                0: if (rv) begin rd_addr_m = ra; rd_phase = 1; end
                1: begin
                    rd_data_m = (ZP && rd_addr_m == 0) ? '0 : exp_mem[rd_addr_m];
                    rd_phase = 2;
                end
                default: if (rk) rd_phase = 0;
            endcase
            pend_we = (cacc || dacc) && !(ZP && ((cacc ? ca : da) == 0));
            if (cacc) begin pend_addr = ca; pend_data = cd; end
            else if (dacc) begin pend_addr = da; pend_data = dd; end
            if (!dv || dacc) cnt_m = 0;
            else if (cnt_m < STARVE_MAX) cnt_m++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        core_wr_valid = 1'b1; dbg_wr_valid = 1'b1; dbg_rd_valid = 1'b1;
        tick();
        tick();
        checks++; if (core_wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_ready: got %b expected 0", core_wr_ready); end
        checks++; if (dbg_wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbg_wr_ready: got %b expected 0", dbg_wr_ready); end
        checks++; if (dbg_rd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_ready: got %b expected 0", dbg_rd_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we: got %b expected 0", rf_we); end
        checks++; if (dbg_rd_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", dbg_rd_rvalid); end
        checks++; if (rf_waddr !== '0 || rf_raddr !== '0) begin errors++; $display("[TB] FAIL reset_addrs: got waddr %h raddr %h expected 0", rf_waddr, rf_raddr); end
        checks++; if (rf_wdata !== '0 || dbg_rd_rdata !== '0) begin errors++; $display("[TB] FAIL reset_data: got wdata %h rdata %h expected 0", rf_wdata, dbg_rd_rdata); end
        checks++; if (starve_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_starve: got %0d expected 0", starve_cnt); end
        // First edge after release must already accept.
        reset_n = 1'b1;
        idle_inputs();
        core_wr_valid = 1'b1; core_wr_addr = 5'd2; core_wr_data = 32'h2222_0002;
        @(negedge clk);
        checks++; if (core_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_core_ready: got %b expected 1", core_wr_ready); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2) begin errors++; $display("[TB] FAIL release_first_write: got we %b addr %0d expected 1 2", rf_we, rf_waddr); end
        idle_inputs();
        tick();
    endtask

    task automatic test_core_write();
        core_wr_valid = 1'b1; core_wr_addr = 5'd3; core_wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (core_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL core_ready: got %b expected 1", core_wr_ready); end
        tick();
        core_wr_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL core_write: got we %b addr %0d data %h expected 1 3 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL core_we_drop: got %b expected 0", rf_we); end
        for (int i = 0; i < 8; i++) begin
            core_wr_valid = 1'($urandom_range(0, 1));
            core_wr_addr  = ADDR_W'($urandom);
            core_wr_data  = $urandom;
            tick();
            checks++; if (rf_we !== pend_we || (pend_we && (rf_waddr !== pend_addr || rf_wdata !== pend_data))) begin
                errors++; $display("[TB] FAIL core_rand_write: got we %b addr %0d data %h expected %b %0d %h", rf_we, rf_waddr, rf_wdata, pend_we, pend_addr, pend_data);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_contention();
        int acc_cycle = 0;
        dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd7; dbg_wr_data = 32'h12;
        for (int c = 1; c <= 10; c++) begin
            core_wr_valid = 1'b1;
            core_wr_addr  = ADDR_W'($urandom_range(8, 31));
            core_wr_data  = $urandom;
            @(negedge clk);
            checks++; if (core_wr_ready !== m_core_rdy() || dbg_wr_ready !== m_dbg_rdy()) begin
                errors++; $display("[TB] FAIL contend_ready c%0d: got core %b dbg %b expected %b %b", c, core_wr_ready, dbg_wr_ready, m_core_rdy(), m_dbg_rdy());
            end
            checks++; if (starve_cnt !== 3'(cnt_m)) begin errors++; $display("[TB] FAIL contend_starve c%0d: got %0d expected %0d", c, starve_cnt, cnt_m); end
            if (dbg_wr_ready === 1'b1) acc_cycle = c;
            tick();
            if (acc_cycle != 0) break;
        end
        idle_inputs();
        checks++; if (acc_cycle != STARVE_MAX + 1) begin errors++; $display("[TB] FAIL contend_grant_cycle: got %0d expected %0d", acc_cycle, STARVE_MAX + 1); end
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h12) begin
            errors++; $display("[TB] FAIL contend_dbg_write: got we %b addr %0d data %h expected 1 7 12", rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (starve_cnt !== 3'd0) begin errors++; $display("[TB] FAIL contend_starve_clear: got %0d expected 0", starve_cnt); end
        tick();
    endtask

    task automatic test_debug_read();
        logic [DATA_W-1:0] held;
        dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd5; dbg_wr_data = 32'h55;
        @(negedge clk);
        checks++; if (dbg_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL dbg_wr_ready_idle: got %b expected 1", dbg_wr_ready); end
        tick();
        idle_inputs();
        tick();
        dbg_rd_valid = 1'b1; dbg_rd_addr = 5'd5;
        @(negedge clk);
        checks++; if (dbg_rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_ready: got %b expected 1", dbg_rd_ready); end
        tick();
        dbg_rd_valid = 1'b0;
        checks++; if (dbg_rd_rvalid !== 1'b0 || dbg_rd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rd_issue: got rvalid %b ready %b expected 0 0", dbg_rd_rvalid, dbg_rd_ready); end
        tick();
        checks++; if (dbg_rd_rvalid !== 1'b1 || dbg_rd_rdata !== 32'h55) begin errors++; $display("[TB] FAIL rd_resp: got rvalid %b data %h expected 1 55", dbg_rd_rvalid, dbg_rd_rdata); end
        held = dbg_rd_rdata;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dbg_rd_rvalid !== 1'b1 || dbg_rd_rdata !== 32'h55 || dbg_rd_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL rd_hold: got rvalid %b data %h ready %b expected 1 %h 0", dbg_rd_rvalid, dbg_rd_rdata, dbg_rd_ready, held);
            end
        end
        dbg_rd_rack = 1'b1;
        tick();
        dbg_rd_rack = 1'b0;
        @(negedge clk);
        checks++; if (dbg_rd_rvalid !== 1'b0 || dbg_rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_release: got rvalid %b ready %b expected 0 1", dbg_rd_rvalid, dbg_rd_ready); end
    endtask

    task automatic test_bypass();
        core_wr_valid = 1'b1; core_wr_addr = 5'd9; core_wr_data = 32'hA5A5_A5A5;
        dbg_rd_valid  = 1'b1; dbg_rd_addr  = 5'd9;
        tick();
        idle_inputs();
        tick();
        checks++; if (dbg_rd_rvalid !== 1'b1 || dbg_rd_rdata !== 32'hA5A5_A5A5) begin
            errors++; $display("[TB] FAIL bypass: got rvalid %b data %h expected 1 a5a5a5a5", dbg_rd_rvalid, dbg_rd_rdata);
        end
        dbg_rd_rack = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        dbg_rd_valid = 1'b1; dbg_rd_addr = 5'd5;
        tick();
        idle_inputs();
        core_wr_valid = 1'b1; core_wr_addr = 5'd10; core_wr_data = 32'h1010;
        dbg_wr_valid  = 1'b1; dbg_wr_addr  = 5'd11; dbg_wr_data  = 32'h1111;
        tick();
        tick();
        checks++; if (dbg_rd_rvalid !== 1'b1 || starve_cnt !== 3'(cnt_m)) begin
            errors++; $display("[TB] FAIL pre_reset_state: got rvalid %b starve %0d expected 1 %0d", dbg_rd_rvalid, starve_cnt, cnt_m);
        end
        reset_n = 1'b0;
        idle_inputs();
        tick();
        checks++; if (dbg_rd_rvalid !== 1'b0 || starve_cnt !== 3'd0 || rf_we !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_read_reset: got rvalid %b starve %0d we %b expected 0 0 0", dbg_rd_rvalid, starve_cnt, rf_we);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (dbg_rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle: got ready %b expected 1", dbg_rd_ready); end
        tick();
    endtask

`ifdef REGARB_ZERO_PROTECT_EN
    task automatic test_zero_protect();
        core_wr_valid = 1'b1; core_wr_addr = 5'd0; core_wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (core_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL zp_ready: got %b expected 1", core_wr_ready); end
        tick();
        idle_inputs();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL zp_we: got %b expected 0", rf_we); end
        dbg_rd_valid = 1'b1; dbg_rd_addr = 5'd0;
        tick();
        idle_inputs();
        tick();
        checks++; if (dbg_rd_rvalid !== 1'b1 || dbg_rd_rdata !== '0) begin errors++; $display("[TB] FAIL zp_read: got rvalid %b data %h expected 1 0", dbg_rd_rvalid, dbg_rd_rdata); end
        dbg_rd_rack = 1'b1;
        tick();
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            core_wr_valid = ($urandom_range(0, 9) < 6);
            core_wr_addr  = ADDR_W'($urandom);
            core_wr_data  = $urandom;
            if (!dbg_wr_valid || last_dacc) begin
                dbg_wr_valid = ($urandom_range(0, 9) < 4);
                dbg_wr_addr  = ADDR_W'($urandom);
                dbg_wr_data  = $urandom;
            end
            dbg_rd_valid = ($urandom_range(0, 9) < 3);
            dbg_rd_addr  = ADDR_W'($urandom);
            dbg_rd_rack  = (rd_phase == 2) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            checks++; if (core_wr_ready !== m_core_rdy() || dbg_wr_ready !== m_dbg_rdy() || dbg_rd_ready !== m_rd_rdy()) begin
                errors++; $display("[TB] FAIL rand_ready %0d: got %b%b%b expected %b%b%b", i, core_wr_ready, dbg_wr_ready, dbg_rd_ready, m_core_rdy(), m_dbg_rdy(), m_rd_rdy());
            end
            tick();
            checks++; if (rf_we !== pend_we || (pend_we && (rf_waddr !== pend_addr || rf_wdata !== pend_data))) begin
                errors++; $display("[TB] FAIL rand_write %0d: got we %b addr %0d data %h expected %b %0d %h", i, rf_we, rf_waddr, rf_wdata, pend_we, pend_addr, pend_data);
            end
            checks++; if (starve_cnt !== 3'(cnt_m) || dbg_rd_rvalid !== (rd_phase == 2)) begin
                errors++; $display("[TB] FAIL rand_state %0d: got starve %0d rvalid %b expected %0d %b", i, starve_cnt, dbg_rd_rvalid, cnt_m, rd_phase == 2);
            end
            if (rd_phase == 2) begin
                checks++; if (dbg_rd_rdata !== rd_data_m) begin errors++; $display("[TB] FAIL rand_rdata %0d: got %h expected %h", i, dbg_rd_rdata, rd_data_m); end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        cnt_m = 0; pend_we = 1'b0; pend_addr = '0; pend_data = '0;
        rd_phase = 0; rd_addr_m = '0; rd_data_m = '0; last_dacc = 1'b0;
        reset_n = 1'b0;
        idle_inputs();
        $display("[TB] starting regfile_arbiter bench");
        test_reset();
        test_core_write();
        test_contention();
        test_debug_read();
        test_bypass();
        test_reset_mid_read();
`ifdef REGARB_ZERO_PROTECT_EN
        test_zero_protect();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
